// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the fixed constants of the
// double-dabble datapath (digit count, BCD field width, saturation
// value and the add-3 adjust threshold).
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NDIG    = 4;
  localparam int BCD_W   = 16;
  localparam int SAT_VAL = 9999;
  localparam int ADJ_THR = 5;

endpackage

// File: rtl/bin2bcd_if.sv
// Handshake and result bundle of the binary-to-BCD converter.
// master: requester side (drives start/value, observes busy/done/ovf/hex*).
// slave : converter side.
//   start  - conversion request, honoured only while the converter is idle
//   value  - unsigned operand, WIDTH bits
//   busy   - conversion in progress
//   done   - one-cycle pulse when new digits are presented
//   ovf    - last captured operand exceeded 9999 (digits saturated)
//   hex3..hex0 - BCD thousands..units digits, held between results
interface bin2bcd_if #(
  parameter int WIDTH = 14
);

  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       hex3;
  logic [3:0]       hex2;
  logic [3:0]       hex1;
  logic [3:0]       hex0;

  modport master (
    output start, value,
    input  busy, done, ovf, hex3, hex2, hex1, hex0
  );

  modport slave (
    input  start, value,
    output busy, done, ovf, hex3, hex2, hex1, hex0
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble adjust: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
//   nib - BCD digit before the shift
//   adj - adjusted digit (4-bit result, any carry is dropped)
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  assign adj = (nib >= 4'(ADJ_THR)) ? nib + 4'd3 : nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter feeding the seven-segment digit mux.
// Converts one operand bit per clock with shift-add-3; operands above 9999
// still run the full WIDTH shifts but publish 9,9,9,9 with ovf set.
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset, aborts any conversion
//   bus   - bin2bcd_if slave: start/value in, busy/done/ovf/hex3..hex0 out
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic      clk,
  input  logic      reset,
  bin2bcd_if.slave  bus
);

  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [SR_W-1:0]  sreg;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             value_over;
  logic             last_shift;
  logic [BCD_W-1:0] adj_bcd;

  logic             load;
  logic             shift_en;
  logic             publish;

  // Widening to 32 bits keeps the compare unsigned and makes it fold to a
  // constant 0 when WIDTH cannot represent anything above 9999.
  assign value_over = 32'(bus.value) > 32'(SAT_VAL);
  assign last_shift = (cnt == CNT_W'(WIDTH - 1));

  // One adjust cell per BCD digit, sitting on the upper BCD_W bits.
  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_add3 u_add3 (
      .nib (sreg[WIDTH + 4*g +: 4]),
      .adj (adj_bcd[4*g +: 4])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: SHIFT runs exactly WIDTH cycles, DONE lasts one.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = SHIFT;
      SHIFT:   if (last_shift) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-state control strobes for the datapath and output registers.
  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    publish  = 1'b0;
    case (state)
      IDLE:    load     = bus.start;
      SHIFT:   shift_en = 1'b1;
      DONE:    publish  = 1'b1;
      default: ;
    endcase
  end

  // Shift register, bit counter and saturation flag. The adjusted digits
  // and the remaining binary bits shift together; whatever falls out of the
  // top of the thousands digit is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
      cnt  <= '0;
      sat  <= 1'b0;
    end else if (load) begin
      sreg <= {{BCD_W{1'b0}}, bus.value};
      cnt  <= '0;
      sat  <= value_over;
    end else if (shift_en) begin
      sreg <= {adj_bcd, sreg[WIDTH-1:0]} << 1;
      cnt  <= cnt + 1'b1;
    end
  end

  // Registered outputs. busy trails the state by one edge so it stays high
  // through the cycle in which done is shown, and the digits only change on
  // the DONE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.hex3 <= 4'd0;
      bus.hex2 <= 4'd0;
      bus.hex1 <= 4'd0;
      bus.hex0 <= 4'd0;
    end else begin
      bus.busy <= (state != IDLE);
      bus.done <= publish;
      if (publish) begin
        bus.ovf <= sat;
        if (sat) begin
          bus.hex3 <= 4'd9;
          bus.hex2 <= 4'd9;
          bus.hex1 <= 4'd9;
          bus.hex0 <= 4'd9;
        end else begin
          bus.hex3 <= sreg[WIDTH + 12 +: 4];
          bus.hex2 <= sreg[WIDTH + 8  +: 4];
          bus.hex1 <= sreg[WIDTH + 4  +: 4];
          bus.hex0 <= sreg[WIDTH      +: 4];
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (WIDTH = 14). Expected digits come
// from plain decimal arithmetic on min(value, 9999).
module tb_bin2bcd_seq;

  localparam int WIDTH = 14;
  localparam int LAT   = WIDTH + 1;

  logic clk = 1'b0;
  logic reset;

  int check_count = 0;
  int pass_count  = 0;

  always #5 clk = ~clk;

  bin2bcd_if #(.WIDTH(WIDTH)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Decimal digits of the saturated operand, packed thousands..units.
  function automatic logic [15:0] ref_digits(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] hex_obs();
    return {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with v for one cycle and wait (bounded) for done.
  // lat is the cycle of done counted from the accepting edge, -1 on timeout.
  task automatic applyStimulus(input int v, output int lat);
    bus.value = WIDTH'(v);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [18:0] obs;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.value = '0;
    tick();
    tick();
    reset = 1'b0;
    obs = {bus.busy, bus.done, bus.ovf, hex_obs()};
    check_count++;
    if (obs !== 19'd0) $display("[TB] FAIL reset_state: got %h expected %h", obs, 19'd0);
    else pass_count++;
  endtask

  task automatic test_zero();
    logic [1:0] exp_bd;
    bus.value = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp_bd = {(k <= LAT), (k == LAT)};
      check_count++;
      if ({bus.busy, bus.done} !== exp_bd)
        $display("[TB] FAIL zero_busy_done cycle %0d: got %b expected %b", k, {bus.busy, bus.done}, exp_bd);
      else pass_count++;
      if (k == LAT) begin
        check_count++;
        if ({bus.ovf, hex_obs()} !== 17'd0)
          $display("[TB] FAIL zero_result: got %h expected %h", {bus.ovf, hex_obs()}, 17'd0);
        else pass_count++;
      end
    end
  endtask

  task automatic test_values();
    int lat;
    applyStimulus(1234, lat);
    check_count++;
    if (lat !== LAT) $display("[TB] FAIL v1234_latency: got %0d expected %0d", lat, LAT);
    else pass_count++;
    check_count++;
    if ({bus.ovf, hex_obs()} !== {1'b0, ref_digits(1234)})
      $display("[TB] FAIL v1234_result: got %h expected %h", {bus.ovf, hex_obs()}, {1'b0, ref_digits(1234)});
    else pass_count++;

    // Digits must hold the previous result until the new done.
    bus.value = WIDTH'(9999);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      check_count++;
      if (hex_obs() !== ref_digits(1234))
        $display("[TB] FAIL hold_digits cycle %0d: got %h expected %h", k, hex_obs(), ref_digits(1234));
      else pass_count++;
    end
    check_count++;
    if (lat !== LAT) $display("[TB] FAIL v9999_latency: got %0d expected %0d", lat, LAT);
    else pass_count++;
    check_count++;
    if ({bus.ovf, hex_obs()} !== {1'b0, ref_digits(9999)})
      $display("[TB] FAIL v9999_result: got %h expected %h", {bus.ovf, hex_obs()}, {1'b0, ref_digits(9999)});
    else pass_count++;
  endtask

  task automatic test_saturation();
    int vals[3] = '{10000, 16383, 7};
    int lat;
    foreach (vals[i]) begin
      applyStimulus(vals[i], lat);
      check_count++;
      if (lat !== LAT) $display("[TB] FAIL sat_latency v=%0d: got %0d expected %0d", vals[i], lat, LAT);
      else pass_count++;
      check_count++;
      if ({bus.ovf, hex_obs()} !== {(vals[i] > 9999), ref_digits(vals[i])})
        $display("[TB] FAIL sat_result v=%0d: got %h expected %h", vals[i],
                 {bus.ovf, hex_obs()}, {(vals[i] > 9999), ref_digits(vals[i])});
      else pass_count++;
    end
  endtask

  task automatic test_held_start();
    int done_k[$];
    logic [15:0] done_hex[$];
    bus.value = WIDTH'(1234);
    bus.start = 1'b1;
    tick();
    for (int k = 1; k <= 36; k++) begin
      if (k == 5) bus.value = WIDTH'(5678);
      tick();
      if (bus.done === 1'b1) begin
        done_k.push_back(k);
        done_hex.push_back(hex_obs());
      end
      if (k == 31) bus.start = 1'b0;
    end
    check_count++;
    if (done_k.size() !== 2) $display("[TB] FAIL held_done_count: got %0d expected %0d", done_k.size(), 2);
    else pass_count++;
    if (done_k.size() >= 2) begin
      check_count++;
      if (done_k[0] !== LAT || done_k[1] !== 2*LAT + 1)
        $display("[TB] FAIL held_done_cycles: got %0d,%0d expected %0d,%0d", done_k[0], done_k[1], LAT, 2*LAT + 1);
      else pass_count++;
      check_count++;
      if (done_hex[0] !== ref_digits(1234) || done_hex[1] !== ref_digits(5678))
        $display("[TB] FAIL held_results: got %h,%h expected %h,%h", done_hex[0], done_hex[1],
                 ref_digits(1234), ref_digits(5678));
      else pass_count++;
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen_done = 0;
    bus.value = WIDTH'(4321);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_count++;
    if ({bus.busy, bus.done, bus.ovf, hex_obs()} !== 19'd0)
      $display("[TB] FAIL abort_outputs: got %h expected %h", {bus.busy, bus.done, bus.ovf, hex_obs()}, 19'd0);
    else pass_count++;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.done === 1'b1) seen_done++;
    end
    check_count++;
    if (seen_done !== 0) $display("[TB] FAIL abort_no_done: got %0d expected %0d", seen_done, 0);
    else pass_count++;
    applyStimulus(42, lat);
    check_count++;
    if (lat !== LAT || {bus.ovf, hex_obs()} !== {1'b0, ref_digits(42)})
      $display("[TB] FAIL after_abort v42: got lat %0d %h expected lat %0d %h", lat,
               {bus.ovf, hex_obs()}, LAT, {1'b0, ref_digits(42)});
    else pass_count++;
  endtask

  task automatic test_random();
    int lat;
    int v;
    int edges[6] = '{9998, 9999, 10000, 10001, 16383, 1};
    for (int i = 0; i < 306; i++) begin
      v = (i < 6) ? edges[i] : int'($urandom_range(0, 16383));
      applyStimulus(v, lat);
      check_count++;
      if (lat !== LAT || {bus.ovf, hex_obs()} !== {(v > 9999), ref_digits(v)})
        $display("[TB] FAIL random v=%0d: got lat %0d %h expected lat %0d %h", v, lat,
                 {bus.ovf, hex_obs()}, LAT, {(v > 9999), ref_digits(v)});
      else pass_count++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.value = '0;
    reset     = 1'b1;
    test_reset();
    test_zero();
    test_values();
    test_saturation();
    test_held_start();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that drives the four hex digit inputs of the multiplexed seven-segment display. It takes an unsigned binary count, for example the mine counter or the game timer, and produces four BCD digits using an iterative shift-add-3 (double-dabble) algorithm, one bit per clock. A start/busy/done handshake controls it. Values above 9999 saturate to 9999 and raise an overflow flag.

## Interface
- `WIDTH`, default 14: binary input width. Legal range is 4..16.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: conversion request. Sampled only in IDLE.
- `value`  in  WIDTH: unsigned binary operand. Captured on the accepted `start` cycle.
- `busy`  out  1: high while state ≠ IDLE.
- `done`  out  1: one-cycle pulse when a new result is presented.
- `ovf`  out  1: the last captured value was >9999. Held until the next result.
- `hex3`  out  4: BCD thousands digit. Held until the next result.
- `hex2`  out  4: BCD hundreds digit. Held.
- `hex1`  out  4: BCD tens digit. Held.
- `hex0`  out  4: BCD units digit. Held.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - When `start`=1, load the shift register {16'b0, value}, clear the bit counter, and latch `sat = (value > 9999)`.
  - Then go to SHIFT. When `start`=0, stay in IDLE.
- SHIFT, every cycle:
  - For each of the 4 BCD nibbles, add 3 if the nibble is ≥5.
  - Then shift the whole register left by 1.
  - Increment the counter.
  - After the WIDTH-th shift (counter == WIDTH-1 at the shift), go to DONE.
- DONE, for one cycle:
  - Register the hex outputs: 9,9,9,9 if `sat`, otherwise the BCD nibbles [15:12]..[3:0].
  - Set `ovf <= sat` and `done <= 1`.
  - Then go to IDLE.
- Saturated conversions still run the full WIDTH shifts, so latency is fixed. Nibble overflow in the thousands digit when `sat`=1 is discarded.
- `start` while `busy`=1 (SHIFT or DONE) is ignored. It is not queued.
- `value` is don't-care outside the accepting cycle.
- Arithmetic:
  - Shift register is 16+WIDTH bits.
  - add-3 results are 4-bit. No carry across nibbles is needed for legal (≤9999) inputs.
  - The comparison against 9999 is unsigned at WIDTH bits. For WIDTH < 14, `sat` is constant 0.
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `ovf`=0.
  - `hex3`..`hex0`=0.
  - Shift register and counter 0.
- Reset mid-conversion aborts the conversion: no `done`, outputs return to 0 on the next edge.

## Timing
- Accepting edge (cycle 0): `start`=1 in IDLE.
- `busy` is 1 from cycle 1 through cycle WIDTH+1.
- `done`=1 and the new hex/ovf values are visible in cycle WIDTH+1. For WIDTH=14 that is cycle 15.
- Cycle WIDTH+2:
  - State is IDLE and `busy`=0.
  - A `start` here is accepted.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Outputs are glitch-free. All outputs are registered, and hex digits change only on the DONE edge.

## Structure
- Package `bin2bcd_pkg`:
  - FSM state enum (IDLE/SHIFT/DONE).
  - `NDIG`=4.
  - `BCD_W`=16.
  - `SAT_VAL`=9999.
  - `ADJ_THR`=5.
- Sub-module `bcd_add3`: 4-bit combinational nibble adjust, out = in≥5 ? in+3 : in. Instantiated NDIG times.
- Counter width: $clog2(WIDTH).

## Test plan
- `value`=0, `start` pulse → `done` at cycle 15 with hex=0,0,0,0, `ovf`=0, `busy` high for cycles 1..15.
- `value`=1234 → hex3..0 = 1,2,3,4, `ovf`=0. Then `value`=9999 → 9,9,9,9, `ovf`=0.
- `value`=10000, and then 16383 → hex = 9,9,9,9, `ovf`=1, same latency. A following `value`=7 → 0,0,0,7, `ovf`=0.
- `start` held high with `value` changed mid-conversion (1234, then 5678 at cycle 5) → result 1,2,3,4. The second `start` is accepted only at cycle 16; 5,6,7,8 arrives at cycle 31.
- `reset` asserted at cycle 8 of converting 4321 → no `done`, hex=0, `busy`=0 next cycle. A fresh `start` with 42 → 0,0,4,2 after 15 cycles.
- Exhaustive random check (WIDTH=14, 0..16383) against a reference model: digits equal min(v,9999) decimal, and `ovf` matches v>9999.
